conv_window_gen: RTL and testbench
==================================

# conv_window_gen

Streaming sliding-window generator that feeds the convolution filter datapath. It accepts a raster-order pixel stream for one input channel and emits every valid (no padding) FN×FN window as a flat signed bus. The window matches the filter's `x_<j>_<i>` operand set. It sits between the feature-map memory reader and the filter array, one instance per input channel.

## Interface

Parameters:
- `WIDTH`, 10: signed pixel width; matches the filter operand width.
- `IMG_W`, 28: image width in pixels; must be ≥ FN.
- `IMG_H`, 28: image height in pixels; must be ≥ FN.
- `FN`, 3: window edge; must be ≥ 2.

Ports:
- `clk`  in  1  — system clock; all logic is on the rising edge.
- `reset`  in  1  — asynchronous, active-high reset.
- `in_valid`  in  1  — a pixel is presented on `in_data`.
- `in_data`  in  WIDTH, signed  — pixel, raster order.
- `in_ready`  out  1  — the block can accept a pixel this cycle.
- `out_valid`  out  1  — `win` holds a valid window.
- `out_ready`  in  1  — the downstream filter takes the window.
- `win`  out  FN*FN*WIDTH  — element (j,i) is at bits `[(j*FN+i)*WIDTH +: WIDTH]`; j = row offset, i = column offset; (0,0) is top-left.
- `win_row`  out  8  — output row index of the window, 0..IMG_H-FN.
- `win_col`  out  8  — output column index of the window, 0..IMG_W-FN.
- `frame_done`  out  1  — one-cycle pulse after the last window of a frame is accepted.

## Operation

- A pixel is accepted when `in_valid && in_ready`. A window is accepted when `out_valid && out_ready`.
- Storage:
  - FN-1 line buffers of IMG_W × WIDTH, implemented as circular RAM or shift registers.
  - An FN×FN register window that shifts left by one column per accepted pixel. The new right column is {line buffers oldest→newest, in_data}.
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) track the position of the next input pixel. `col` wraps to 0 and increments `row`.
- State machine:
  - IDLE: `col=row=0`. The first accepted pixel moves to FILL, or directly to RUN if FN-1 = 0 rows are needed, which cannot occur since FN ≥ 2.
  - FILL: `row < FN-1`; pixels go only into the line buffers and window, and no output is produced. Moves to RUN when the pixel at (FN-2, IMG_W-1) is accepted.
  - RUN: an accepted pixel at (row, col) with `col ≥ FN-1` loads the output register, sets `out_valid`, and sets `win_row = row-FN+1`, `win_col = col-FN+1`. When the pixel at (IMG_H-1, IMG_W-1) is accepted, moves to DONE.
  - DONE: waits for the final window handshake. In the cycle after it, asserts `frame_done` for one cycle and returns to IDLE with counters and line buffers logically cleared.
- `in_ready = (state != DONE) && (!out_valid || out_ready)`. This single output stage provides backpressure; no pixel is accepted while an unconsumed window is held.
- Columns `col < FN-1` in RUN update the window without producing output. The window is not flushed across line wrap, because left columns are fully replaced before the next valid window.
- Data passes through unmodified: no arithmetic, sign preserved, no clipping.
- Windows per frame: (IMG_W-FN+1)×(IMG_H-FN+1).

## Timing

- Reset values: `in_ready=0` during reset and 1 in the first cycle after release. `out_valid=0`, `win=0`, `win_row=0`, `win_col=0`, `frame_done=0`. State is IDLE and all counters are 0.
- Latency: the window containing pixel (r,c) as its bottom-right element appears with `out_valid=1` exactly 1 cycle after that pixel's acceptance.
- `out_valid`, `win`, `win_row`, and `win_col` are held stable while `out_valid && !out_ready`.
- Simultaneous window acceptance and pixel acceptance in the same cycle is legal, giving full throughput of 1 pixel per cycle. `out_valid` stays high if the new pixel produces a window; otherwise it drops.
- `frame_done` fires 1 cycle after the final window handshake. `in_ready` is 0 from the final pixel's acceptance until the cycle after `frame_done`.
- A `reset` assertion mid-frame immediately clears all outputs and state. The partial window is discarded, and the next pixel after release is treated as (0,0).

## Test plan

- IMG_W=4, IMG_H=4, FN=3, pixels 0..15 streamed back-to-back, `out_ready=1` -> exactly 4 windows, each 1 cycle after pixels 10, 11, 14, and 15. First window is {0,1,2,4,5,6,8,9,10} with (win_row,win_col)=(0,0); last is {5,6,7,9,10,11,13,14,15} at (1,1). `frame_done` pulses 1 cycle after the 4th handshake.
- Same stream with `out_ready=0` for 5 cycles after the first window -> `in_ready=0` and `win` frozen at {0,1,2,4,5,6,8,9,10} throughout. On release the remaining 3 windows are produced correctly and no pixel is lost.
- Random `in_valid` gaps (50%) on the 4×4 frame -> window contents and order are identical to the back-to-back case.
- Signed extremes: all pixels -512 with WIDTH=10 -> every window element reads 10'h200 and no sign corruption occurs.
- `reset` pulse after pixel 9 is accepted, then pixels 0..15 restreamed -> no window is emitted before the new pixel 10. The first window is {0,1,2,4,5,6,8,9,10}.
- Two consecutive 4×4 frames with no idle gap -> 8 windows and two `frame_done` pulses. The second frame's first window contains only second-frame pixels.

Source files
------------

// File: rtl/conv_window_gen_if.sv
// Streaming handshake bundle for the sliding-window generator: a pixel
// input channel and a window output channel.
interface conv_window_gen_if #(
  parameter int WIDTH = 10,
  parameter int FN    = 3
);
  logic                      in_valid;
  logic signed [WIDTH-1:0]   in_data;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [FN*FN*WIDTH-1:0]    win;
  logic [7:0]                win_row;
  logic [7:0]                win_col;
  logic                      frame_done;

  // Upstream pixel source and downstream window sink.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, win, win_row, win_col, frame_done
  );

  // The window generator itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, win, win_row, win_col, frame_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// Sliding FN x FN window generator for one input channel. Pixels arrive in
// raster order; FN-1 line buffers supply the older rows of the column being
// entered, the register window shifts left by one column per pixel, and each
// full (unpadded) window is captured into a single output register.
module conv_window_gen #(
  parameter int WIDTH = 10,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int FN    = 3
) (
  input  logic             clk,
  input  logic             reset,
  conv_window_gen_if.slave bus
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int WB = FN * FN * WIDTH;

  localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_FIRST_OUT = CW'(FN - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_FILL_LAST = RW'(FN - 2);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic                    ready;
  logic                    accept;
  logic                    out_take;
  logic                    emit;
  logic                    at_fill_end;
  logic                    at_frame_end;
  logic                    frame_done_q;

  // Line buffers: lb[0] holds the oldest row, lb[FN-2] the most recent one.
  logic signed [WIDTH-1:0] lb [FN-1][IMG_W];
  logic signed [WIDTH-1:0] tap [FN];
  logic signed [WIDTH-1:0] win_p0 [FN][FN];
  logic signed [WIDTH-1:0] win_nxt [FN][FN];
  logic [WB-1:0]           win_flat;

  logic                    vld_p1;
  logic [WB-1:0]           win_p1;
  logic [7:0]              win_row_p1;
  logic [7:0]              win_col_p1;

  // Handshake qualifiers; a held window blocks new pixels unless it is taken
  // in the same cycle, which keeps one pixel per cycle at full throughput.
  always_comb begin
    ready        = !reset && (state != DONE) && (!vld_p1 || bus.out_ready);
    accept       = bus.in_valid && ready;
    out_take     = vld_p1 && bus.out_ready;
    at_fill_end  = (row == ROW_FILL_LAST) && (col == COL_LAST);
    at_frame_end = (row == ROW_LAST) && (col == COL_LAST);
    emit         = accept && (state == RUN) && (col >= COL_FIRST_OUT);
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept) state_nxt = at_fill_end ? RUN : FILL;
      FILL: if (accept && at_fill_end) state_nxt = RUN;
      RUN:  if (accept && at_frame_end) state_nxt = DONE;
      DONE: if (frame_done_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Column entering the window: line-buffer taps oldest to newest, then the
  // incoming pixel at the bottom; the window image after the left shift.
  always_comb begin
    win_flat = '0;
    for (int k = 0; k < FN - 1; k++) tap[k] = lb[k][col];
    tap[FN-1] = bus.in_data;
    for (int j = 0; j < FN; j++) begin
      for (int i = 0; i < FN - 1; i++) win_nxt[j][i] = win_p0[j][i+1];
      win_nxt[j][FN-1] = tap[j];
    end
    for (int j = 0; j < FN; j++)
      for (int i = 0; i < FN; i++)
        win_flat[(j*FN+i)*WIDTH +: WIDTH] = win_nxt[j][i];
  end

  // Sequencer state and position of the next input pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Stage p0: line buffers rotate one row per column and the window slides
  // left. Stale contents need no clearing because FILL rewrites every line
  // buffer entry and the left window columns are replaced before first use.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < FN - 2; k++) lb[k][col] <= lb[k+1][col];
      lb[FN-2][col] <= bus.in_data;
      win_p0        <= win_nxt;
    end
  end

  // Stage p1: output register, held until the downstream filter takes it;
  // frame_done follows the handshake of the frame's last window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      win_p1       <= '0;
      win_row_p1   <= '0;
      win_col_p1   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= (state == DONE) && out_take;
      if (emit) begin
        vld_p1     <= 1'b1;
        win_p1     <= win_flat;
        win_row_p1 <= 8'(int'(row) - (FN - 1));
        win_col_p1 <= 8'(int'(col) - (FN - 1));
      end else if (out_take) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = vld_p1;
  assign bus.win        = win_p1;
  assign bus.win_row    = win_row_p1;
  assign bus.win_col    = win_col_p1;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen on a 4x4 image with 3x3 windows. A frame-level
// model stores accepted pixels in an image array and cuts each expected
// window straight out of it, tracking when the output register holds it.
module tb_conv_window_gen;
  localparam int WIDTH = 10;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int FN    = 3;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int WB    = FN * FN * WIDTH;

  logic clk = 1'b0;
  logic reset;

  conv_window_gen_if #(.WIDTH(WIDTH), .FN(FN)) bus ();

  conv_window_gen #(.WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H), .FN(FN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic signed [WIDTH-1:0] img [NPIX];
  int                      pix_n;
  bit                      m_vld, m_done_phase, m_fd;
  logic [WB-1:0]           m_win;
  int                      m_wr, m_wc;

  // Stimulus controls
  logic signed [WIDTH-1:0] pq [$];
  int                      gap_pct;
  bit                      rand_ordy;
  bit                      stall_armed;
  int                      stall_cnt;
  bit                      check_neg;

  // Bookkeeping
  int                      n_cmp, n_bad;
  int                      win_cnt, fd_cnt;
  bit                      first_seen;
  logic [WB-1:0]           first_win;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Compare the DUT against the model, then advance the model by one clock.
  task automatic step();
    bit exp_rdy, pacc, wacc, fd_nxt;
    int r, c;
    exp_rdy = !m_done_phase && (!m_vld || bus.out_ready);
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("out_valid", bus.out_valid, m_vld);
    chk("frame_done", bus.frame_done, m_fd);
    if (m_vld) begin
      chk("win", bus.win, m_win);
      chk("win_row", bus.win_row, m_wr);
      chk("win_col", bus.win_col, m_wc);
      if (check_neg)
        for (int k = 0; k < FN * FN; k++) chk("neg_elem", bus.win[k*WIDTH +: WIDTH], 10'h200);
    end
    if (bus.frame_done) fd_cnt++;
    if (bus.out_valid && bus.out_ready) win_cnt++;
    if (!first_seen && bus.out_valid) begin
      first_seen = 1'b1;
      first_win  = bus.win;
    end

    pacc   = bus.in_valid && exp_rdy;
    wacc   = m_vld && bus.out_ready;
    fd_nxt = wacc && m_done_phase;
    if (m_fd) m_done_phase = 1'b0;
    m_fd = fd_nxt;
    if (wacc) m_vld = 1'b0;
    if (pacc) begin
      img[pix_n] = bus.in_data;
      r = pix_n / IMG_W;
      c = pix_n % IMG_W;
      if (r >= FN - 1 && c >= FN - 1) begin
        m_vld = 1'b1;
        m_wr  = r - FN + 1;
        m_wc  = c - FN + 1;
        for (int j = 0; j < FN; j++)
          for (int i = 0; i < FN; i++)
            m_win[(j*FN+i)*WIDTH +: WIDTH] = img[(m_wr + j) * IMG_W + m_wc + i];
        if (stall_armed) begin
          stall_cnt   = 5;
          stall_armed = 1'b0;
        end
      end
      if (pix_n == NPIX - 1) begin
        pix_n        = 0;
        m_done_phase = 1'b1;
      end else begin
        pix_n++;
      end
      void'(pq.pop_front());
    end
  endtask

  task automatic drive();
    if (pq.size() > 0 && $urandom_range(99) >= gap_pct) begin
      bus.in_valid = 1'b1;
      bus.in_data  = pq[0];
    end else begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
    end
    if (stall_cnt > 0) begin
      bus.out_ready = 1'b0;
      stall_cnt--;
    end else begin
      bus.out_ready = rand_ordy ? 1'($urandom_range(1)) : 1'b1;
    end
  endtask

  task automatic run(input int max_cyc, input bit wait_idle);
    int n;
    n = 0;
    drive();
    while ((pq.size() > 0 || (wait_idle && (m_vld || m_done_phase || m_fd))) && n < max_cyc) begin
      @(negedge clk);
      step();
      @(posedge clk);
      #1;
      drive();
      n++;
    end
    chk("run_budget", n < max_cyc, 1'b1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    m_vld = 1'b0; m_done_phase = 1'b0; m_fd = 1'b0; pix_n = 0;
    stall_cnt = 0; stall_armed = 1'b0;
    pq.delete();
    #2;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_win", bus.win, '0);
    chk("rst_win_row", bus.win_row, 8'd0);
    chk("rst_win_col", bus.win_col, 8'd0);
    chk("rst_frame_done", bus.frame_done, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic new_test(input int gap, input bit rnd);
    gap_pct = gap; rand_ordy = rnd; check_neg = 1'b0;
    win_cnt = 0; fd_cnt = 0; first_seen = 1'b0;
  endtask

  task automatic push_ramp(input int base, input int n);
    for (int k = 0; k < n; k++) pq.push_back(WIDTH'(base + k));
  endtask

  initial begin
    int            fw_vals [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    logic [WB-1:0] fw_exp;
    n_cmp = 0; n_bad = 0;
    for (int k = 0; k < 9; k++) fw_exp[k*WIDTH +: WIDTH] = WIDTH'(fw_vals[k]);
    new_test(0, 1'b0);

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    // Back-to-back ramp, sink always ready
    new_test(0, 1'b0);
    push_ramp(0, NPIX);
    run(200, 1'b1);
    chk("t1_first_win", first_win, fw_exp);
    chk("t1_win_cnt", win_cnt, 4);
    chk("t1_fd_cnt", fd_cnt, 1);

    // Sink stalls for 5 cycles after the first window
    new_test(0, 1'b0);
    stall_armed = 1'b1;
    push_ramp(0, NPIX);
    run(200, 1'b1);
    chk("t2_first_win", first_win, fw_exp);
    chk("t2_win_cnt", win_cnt, 4);

    // Random input gaps and random sink readiness, ramp then random pixels
    new_test(50, 1'b1);
    push_ramp(0, NPIX);
    for (int k = 0; k < NPIX; k++) pq.push_back(WIDTH'($urandom_range(1023)));
    run(2000, 1'b1);
    chk("t3_first_win", first_win, fw_exp);
    chk("t3_win_cnt", win_cnt, 8);
    chk("t3_fd_cnt", fd_cnt, 2);

    // Negative full-scale pixels
    new_test(0, 1'b0);
    check_neg = 1'b1;
    for (int k = 0; k < NPIX; k++) pq.push_back(-10'sd512);
    run(200, 1'b1);
    chk("t4_win_cnt", win_cnt, 4);
    check_neg = 1'b0;

    // Reset after pixel 9, then restream the whole frame
    new_test(0, 1'b0);
    push_ramp(0, 10);
    run(200, 1'b0);
    chk("t5_no_early_win", win_cnt, 0);
    do_reset();
    new_test(0, 1'b0);
    push_ramp(0, NPIX);
    run(200, 1'b1);
    chk("t5_first_win", first_win, fw_exp);
    chk("t5_win_cnt", win_cnt, 4);

    // Two frames queued with no idle gap
    new_test(0, 1'b0);
    push_ramp(0, NPIX);
    push_ramp(100, NPIX);
    run(400, 1'b1);
    chk("t6_win_cnt", win_cnt, 8);
    chk("t6_fd_cnt", fd_cnt, 2);

    // Random mix over several frames
    new_test(30, 1'b1);
    for (int k = 0; k < 3 * NPIX; k++) pq.push_back(WIDTH'($urandom_range(1023)));
    run(3000, 1'b1);
    chk("t7_win_cnt", win_cnt, 12);
    chk("t7_fd_cnt", fd_cnt, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
